// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
//   Ports: clk, reset (async, active-high); start/op launch an operation on operandA (rs) and
//   operandB (rt); hiWrite/loWrite load writeData into hi/lo (MTHI/MTLO) while idle.
//   busy is high while an operation is in flight; done pulses when hi/lo take a result;
//   divByZero flags the last operation; opError pulses when a start is rejected.
//   Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV/DIVU starts are rejected.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic             opError,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t st;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0] m;
  logic neg_p;
  logic sgn, accept, reject;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0] add_sum;
  logic [2*WIDTH-1:0] step_acc, res;
  assign sgn = ~op[0];
  assign mag_a = (sgn && operandA[WIDTH-1]) ? -operandA : operandA;
  assign mag_b = (sgn && operandB[WIDTH-1]) ? -operandB : operandB;
  // Shift-add: upper half accumulates the multiplicand, lower half shifts the multiplier out.
  assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? m : {WIDTH{1'b0}})};
`ifdef MULDIV_DIV_EN
  logic is_div, neg_r, dz;
  logic [WIDTH-1:0] a_raw, quo, rem;
  logic [WIDTH:0] shifted, diff;
  // Restoring step: upper half is the partial remainder, lower half shifts dividend in / quotient out.
  assign shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff = shifted - {1'b0, m};
  assign accept = start && !busy;
  assign reject = 1'b0;
  assign step_acc = !is_div ? {add_sum, acc[WIDTH-1:1]}
                  : diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                  : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign quo = neg_p ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign res = !is_div ? (neg_p ? -acc : acc) : dz ? {a_raw, {WIDTH{1'b1}}} : {rem, quo};
`else
  assign accept = start && !busy && !op[1];
  assign reject = start && !busy && op[1];
  assign step_acc = {add_sum, acc[WIDTH-1:1]};
  assign res = neg_p ? -acc : acc;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      acc <= '0;
      m <= '0;
      neg_p <= 1'b0;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      divByZero <= 1'b0;
      opError <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      a_raw <= '0;
`endif
    end else begin
      done <= 1'b0;
      opError <= reject;
      unique case (st)
        IDLE: begin
          if (accept) begin
            st <= CALC;
            busy <= 1'b1;
            cnt <= '0;
            acc <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
            m <= op[1] ? mag_b : mag_a;
            neg_p <= sgn && (operandA[WIDTH-1] ^ operandB[WIDTH-1]);
            divByZero <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div <= op[1];
            neg_r <= sgn && operandA[WIDTH-1];
            dz <= op[1] && (operandB == '0);
            a_raw <= operandA;
`endif
          end else if (!start) begin
            if (hiWrite) hi <= writeData;
            if (loWrite) lo <= writeData;
          end
        end
        CALC: begin
          acc <= step_acc;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) st <= FIX;
        end
        FIX: begin
          {hi, lo} <= res;
          done <= 1'b1;
          busy <= 1'b0;
          st <= IDLE;
`ifdef MULDIV_DIV_EN
          divByZero <= dz;
`endif
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit downstream of `registerBank`, consuming `readData1` (rs) and `readData2` (rt) for MULT/MULTU/DIV/DIVU. It holds results in architectural HI/LO registers, which are read by MFHI/MFLO and written by MTHI/MTLO. A start/busy/done handshake lets the control unit stall the pipeline while an operation is in flight.

## Interface
- `WIDTH`, 32, operand and HI/LO width; the iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  launch operation; sampled only when `busy`=0
- `op`  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- `operandA`  in  WIDTH  rs value (multiplicand/dividend)
- `operandB`  in  WIDTH  rt value (multiplier/divisor)
- `hiWrite`  in  1  MTHI: load `hi` from `writeData`
- `loWrite`  in  1  MTLO: load `lo` from `writeData`
- `writeData`  in  WIDTH  MTHI/MTLO data
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle pulse when `hi`/`lo` are updated by an operation
- `divByZero`  out  1  sticky flag for the last operation: set if a divide by zero occurred, cleared on the next accepted `start`
- `opError`  out  1  one-cycle pulse when an op is rejected (see Configuration)
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `divByZero`=0, `opError`=0, FSM=IDLE.
- FSM states:
  - IDLE: on `start`, latch `op` and the operand magnitudes (signed ops take absolute values) plus the result signs, clear the counter, go to CALC.
  - CALC: one radix-2 step per cycle for `WIDTH` cycles, then go to FIX.
  - FIX: apply sign correction, write `hi`/`lo`, pulse `done`, return to IDLE.
- Multiply: shift-add over unsigned magnitudes into a 2×WIDTH product. If sign(A)^sign(B) for MULT, negate the full product. `hi`=upper half, `lo`=lower half.
- Divide: restoring division over magnitudes.
  - `lo`=quotient, `hi`=remainder.
  - DIV: quotient negated if sign(A)^sign(B); remainder takes the sign of A.
  - 0x80000000 / 0xFFFFFFFF (DIV): `lo`=0x80000000, `hi`=0, no flag.
- Divide by zero: still runs the full latency; `lo`=0xFFFFFFFF, `hi`=operandA (raw), `divByZero`=1.
- `start` while `busy`=1: ignored, with no effect on the running operation.
- `hiWrite`/`loWrite`:
  - Take effect at the edge only when `busy`=0 and `start`=0.
  - Ignored while busy.
  - If asserted together with `start`, `start` wins and the writes are dropped.
- Operands are captured at the start edge; later changes on `operandA`/`operandB` are don't-care.

## Timing
- Start accepted at edge E0. `busy`=1 from after E0 until after edge E0+`WIDTH`+1.
- `hi`/`lo` update and `done`=1 during the cycle following edge E0+`WIDTH`+1. Total latency is 34 cycles at WIDTH=32.
- `done` and `busy` are never high in the same cycle. A new `start` may be accepted in the same cycle that `done` is high.
- MTHI/MTLO: `hi`/`lo` update at the same edge; the new value is visible in the next cycle.
- `reset` asserted mid-operation aborts immediately and all outputs return to reset values; no `done` is produced.

## Configuration
- `MULDIV_DIV_EN`:
  - Defined: DIV/DIVU are implemented as above.
  - Undefined: no divider logic is built. A `start` with `op`=2/3 is not accepted: `busy` stays 0, there is no `done`, `hi`/`lo` are unchanged, and `opError` pulses for one cycle after that edge. MULT/MULTU are unaffected.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 34 cycles `done`=1, `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT -7 (0xFFFFFFF9) × 3 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV -7 / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIVU 100 / 7 -> `lo`=14, `hi`=2.
- DIVU 0x1234 / 0 -> `lo`=0xFFFFFFFF, `hi`=0x1234, `divByZero`=1; the next accepted start clears it.
- MTHI 0xA5A5A5A5 while idle -> `hi`=0xA5A5A5A5 next cycle. During a busy MULT, `start`/`loWrite` pulses are ignored and `lo` reflects only the MULT result.
- `reset` at cycle 10 of a DIV -> `busy`=0, `hi`=`lo`=0, and no `done`. Without `MULDIV_DIV_EN`: a DIV start gives `opError` for 1 cycle and `busy` stays 0.
